// File: rtl/uart_word_bridge.sv
// uart_word_bridge: moves 32-bit words over a byte-wide UART FIFO interface.
// TX splits a word into four bytes, LSB first; RX assembles four bytes into a
// word and throws away a partial word after RX_TIMEOUT idle cycles.
//
// state   | meaning
// --------+----------------------------------------------------------
// TX_IDLE | waiting for an upstream word
// TX_REQ  | next byte loaded, waiting for room in the send FIFO
// TX_WAIT | send_flag up, holding byte until send_ack
// RX_IDLE | may request a byte; idle timer runs on a partial word
// RX_WAIT | recv_flag up, waiting for recv_ack with the byte
// RX_FULL | word complete, holding rx_word_valid until consumed
module uart_word_bridge #(
   parameter int unsigned RX_TIMEOUT = 1000000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        tx_word_valid,
   input  logic [31:0] tx_word,
   output logic        tx_word_ready,
   output logic        rx_word_valid,
   output logic [31:0] rx_word,
   input  logic        rx_word_ready,
   output logic        rx_drop,
   output logic        send_flag,
   output logic [7:0]  send_data,
   input  logic        send_ack,
   input  logic        sendable,
   output logic        recv_flag,
   input  logic [7:0]  recv_data,
   input  logic        recv_ack,
   input  logic        receivable
);

   typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_WAIT} tx_state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_WAIT, RX_FULL} rx_state_e;

   localparam logic [31:0] TO_LAST = RX_TIMEOUT - 1;

   tx_state_e   tx_state_q, tx_state_d;
   logic [31:0] shift_q, shift_d;
   logic [1:0]  tx_idx_q, tx_idx_d;
   logic        send_flag_q, send_flag_d;
   logic [7:0]  send_data_q, send_data_d;
   logic        tx_rdy_q, tx_rdy_d;
   logic        arm_q;

   rx_state_e   rx_state_q, rx_state_d;
   logic [31:0] rx_word_q, rx_word_d;
   logic [1:0]  rx_idx_q, rx_idx_d;
   logic [31:0] rx_cnt_q, rx_cnt_d;
   logic        rx_valid_q, rx_valid_d;
   logic        recv_flag_q, recv_flag_d;
   logic        rx_drop_q, rx_drop_d;

   // Hold off word acceptance for one edge after reset release.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) arm_q <= 1'b0;
      else      arm_q <= 1'b1;
   end

   // TX next-state: accept word, then four request/ack byte handshakes.
   always_comb begin
      tx_state_d  = tx_state_q;
      shift_d     = shift_q;
      tx_idx_d    = tx_idx_q;
      send_flag_d = send_flag_q;
      send_data_d = send_data_q;
      tx_rdy_d    = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            if (tx_word_valid && arm_q) begin
               tx_rdy_d   = 1'b1;
               shift_d    = tx_word;
               tx_idx_d   = 2'd0;
               tx_state_d = TX_REQ;
            end
         end
         TX_REQ: begin
            if (sendable) begin
               send_data_d = shift_q[7:0];
               send_flag_d = 1'b1;
               tx_state_d  = TX_WAIT;
            end
         end
         TX_WAIT: begin
            if (send_ack) begin
               send_flag_d = 1'b0;
               shift_d     = {8'h00, shift_q[31:8]};
               tx_idx_d    = tx_idx_q + 2'd1;
               tx_state_d  = (tx_idx_q < 2'd3) ? TX_REQ : TX_IDLE;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   // TX registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         tx_state_q  <= TX_IDLE;
         shift_q     <= 32'd0;
         tx_idx_q    <= 2'd0;
         send_flag_q <= 1'b0;
         send_data_q <= 8'd0;
         tx_rdy_q    <= 1'b0;
      end else begin
         tx_state_q  <= tx_state_d;
         shift_q     <= shift_d;
         tx_idx_q    <= tx_idx_d;
         send_flag_q <= send_flag_d;
         send_data_q <= send_data_d;
         tx_rdy_q    <= tx_rdy_d;
      end
   end

   // RX next-state: request bytes, fill lanes, time out partial words.
   always_comb begin
      rx_state_d  = rx_state_q;
      rx_word_d   = rx_word_q;
      rx_idx_d    = rx_idx_q;
      rx_cnt_d    = rx_cnt_q;
      rx_valid_d  = rx_valid_q;
      recv_flag_d = recv_flag_q;
      rx_drop_d   = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_idx_q != 2'd0) begin
               if (rx_cnt_q == TO_LAST) begin
                  rx_idx_d  = 2'd0;
                  rx_cnt_d  = 32'd0;
                  rx_drop_d = 1'b1;
               end else begin
                  rx_cnt_d = rx_cnt_q + 32'd1;
               end
            end
            if (receivable && !rx_valid_q) begin
               recv_flag_d = 1'b1;
               rx_state_d  = RX_WAIT;
            end
         end
         RX_WAIT: begin
            if (recv_ack) begin
               rx_word_d[{rx_idx_q, 3'b000} +: 8] = recv_data;
               rx_idx_d    = rx_idx_q + 2'd1;
               rx_cnt_d    = 32'd0;
               recv_flag_d = 1'b0;
               if (rx_idx_q == 2'd3) begin
                  rx_valid_d = 1'b1;
                  rx_state_d = RX_FULL;
               end else begin
                  rx_state_d = RX_IDLE;
               end
            end
         end
         RX_FULL: begin
            if (rx_word_ready) begin
               rx_valid_d = 1'b0;
               rx_idx_d   = 2'd0;
               rx_state_d = RX_IDLE;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // RX registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rx_state_q  <= RX_IDLE;
         rx_word_q   <= 32'd0;
         rx_idx_q    <= 2'd0;
         rx_cnt_q    <= 32'd0;
         rx_valid_q  <= 1'b0;
         recv_flag_q <= 1'b0;
         rx_drop_q   <= 1'b0;
      end else begin
         rx_state_q  <= rx_state_d;
         rx_word_q   <= rx_word_d;
         rx_idx_q    <= rx_idx_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_valid_q  <= rx_valid_d;
         recv_flag_q <= recv_flag_d;
         rx_drop_q   <= rx_drop_d;
      end
   end

   assign tx_word_ready = tx_rdy_q;
   assign send_flag     = send_flag_q;
   assign send_data     = send_data_q;
   assign rx_word_valid = rx_valid_q;
   assign rx_word       = rx_word_q;
   assign recv_flag     = recv_flag_q;
   assign rx_drop       = rx_drop_q;

endmodule

// File: tb/tb_uart_word_bridge.sv
// Directed bench for uart_word_bridge with RX_TIMEOUT=16.
module tb_uart_word_bridge;

   logic        CLK;
   logic        RST;
   logic        tx_word_valid;
   logic [31:0] tx_word;
   logic        tx_word_ready;
   logic        rx_word_valid;
   logic [31:0] rx_word;
   logic        rx_word_ready;
   logic        rx_drop;
   logic        send_flag;
   logic [7:0]  send_data;
   logic        send_ack;
   logic        sendable;
   logic        recv_flag;
   logic [7:0]  recv_data;
   logic        recv_ack;
   logic        receivable;

   int n_chk = 0;
   int n_bad = 0;
   int rdy_cnt = 0;
   int drop_cnt = 0;
   int rflag_while_valid = 0;
   int sflag_cnt = 0;

   uart_word_bridge #(.RX_TIMEOUT(16)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .tx_word_valid (tx_word_valid),
      .tx_word       (tx_word),
      .tx_word_ready (tx_word_ready),
      .rx_word_valid (rx_word_valid),
      .rx_word       (rx_word),
      .rx_word_ready (rx_word_ready),
      .rx_drop       (rx_drop),
      .send_flag     (send_flag),
      .send_data     (send_data),
      .send_ack      (send_ack),
      .sendable      (sendable),
      .recv_flag     (recv_flag),
      .recv_data     (recv_data),
      .recv_ack      (recv_ack),
      .receivable    (receivable)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Mid-cycle event counters.
   always @(negedge CLK) begin
      if (tx_word_ready) rdy_cnt++;
      if (rx_drop) drop_cnt++;
      if (recv_flag && rx_word_valid) rflag_while_valid++;
      if (send_flag) sflag_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int k = 0;
      while (!tx_word_ready && k < 20) begin
         tick();
         k++;
      end
      chk(tag, {31'd0, tx_word_ready}, 32'd1);
      tx_word_valid = 1'b0;
   endtask

   task automatic send_byte_ack(input logic [7:0] exp, input string tag);
      int k = 0;
      while (!send_flag && k < 100) begin
         tick();
         k++;
      end
      chk({tag, "_flag"}, {31'd0, send_flag}, 32'd1);
      chk({tag, "_data"}, {24'd0, send_data}, {24'd0, exp});
      tick();
      chk({tag, "_hold"}, {23'd0, send_flag, send_data}, {23'd0, 1'b1, exp});
      send_ack = 1'b1;
      tick();
      send_ack = 1'b0;
      chk({tag, "_fall"}, {31'd0, send_flag}, 32'd0);
   endtask

   task automatic recv_byte(input logic [7:0] b, input logic last, input string tag);
      int k = 0;
      while (!recv_flag && k < 100) begin
         tick();
         k++;
      end
      chk({tag, "_rflag"}, {31'd0, recv_flag}, 32'd1);
      tick();
      chk({tag, "_rhold"}, {31'd0, recv_flag}, 32'd1);
      recv_data = b;
      recv_ack  = 1'b1;
      if (last) receivable = 1'b0;
      tick();
      recv_ack = 1'b0;
      chk({tag, "_rfall"}, {31'd0, recv_flag}, 32'd0);
   endtask

   initial begin
      int k;
      int snap;
      RST = 1'b0;
      tx_word_valid = 1'b0;
      tx_word = 32'd0;
      rx_word_ready = 1'b0;
      send_ack = 1'b0;
      sendable = 1'b0;
      recv_data = 8'd0;
      recv_ack = 1'b0;
      receivable = 1'b0;

      // Reset values
      #3;
      chk("rst_ready", {31'd0, tx_word_ready}, 32'd0);
      chk("rst_flags", {29'd0, send_flag, recv_flag, rx_drop}, 32'd0);
      chk("rst_valid", {31'd0, rx_word_valid}, 32'd0);
      chk("rst_sdata", {24'd0, send_data}, 32'd0);
      chk("rst_rword", rx_word, 32'd0);
      tick();
      tick();

      // Send 0x12345678; word already valid at release
      tx_word = 32'h12345678;
      tx_word_valid = 1'b1;
      sendable = 1'b1;
      RST = 1'b1;
      tick();
      chk("rdy_edge1", {31'd0, tx_word_ready}, 32'd0);
      tick();
      chk("rdy_edge2", {31'd0, tx_word_ready}, 32'd1);
      tx_word_valid = 1'b0;
      send_byte_ack(8'h78, "s0");
      send_byte_ack(8'h56, "s1");
      send_byte_ack(8'h34, "s2");
      send_byte_ack(8'h12, "s3");
      tick();
      tick();
      chk("send_rdy_once", rdy_cnt, 32'd1);
      chk("send_idle", {31'd0, send_flag}, 32'd0);

      // Back-pressure after the second byte
      tx_word = 32'h12345678;
      tx_word_valid = 1'b1;
      wait_ready("bp_rdy");
      send_byte_ack(8'h78, "b0");
      send_byte_ack(8'h56, "b1");
      sendable = 1'b0;
      snap = sflag_cnt;
      for (int i = 0; i < 50; i++) tick();
      chk("bp_no_flag", sflag_cnt - snap, 32'd0);
      sendable = 1'b1;
      send_byte_ack(8'h34, "b2");
      send_byte_ack(8'h12, "b3");
      chk("bp_rdy_cnt", rdy_cnt, 32'd2);

      // Receive DEADBEEF with downstream stalled
      receivable = 1'b1;
      recv_byte(8'hEF, 1'b0, "r0");
      recv_byte(8'hBE, 1'b0, "r1");
      recv_byte(8'hAD, 1'b0, "r2");
      recv_byte(8'hDE, 1'b0, "r3");
      receivable = 1'b1;
      chk("rx_valid", {31'd0, rx_word_valid}, 32'd1);
      chk("rx_word", rx_word, 32'hDEADBEEF);
      for (int i = 0; i < 10; i++) tick();
      chk("rx_valid_hold", {31'd0, rx_word_valid}, 32'd1);
      chk("rx_word_hold", rx_word, 32'hDEADBEEF);
      chk("rx_no_req", {31'd0, recv_flag}, 32'd0);
      rx_word_ready = 1'b1;
      receivable = 1'b0;
      tick();
      rx_word_ready = 1'b0;
      chk("rx_consumed", {31'd0, rx_word_valid}, 32'd0);

      // Timeout: two bytes then silence
      receivable = 1'b1;
      recv_byte(8'h11, 1'b0, "t0");
      recv_byte(8'h22, 1'b1, "t1");
      k = 0;
      while (!rx_drop && k < 40) begin
         tick();
         k++;
      end
      chk("to_cycles", k, 32'd16);
      tick();
      chk("to_pulse", {31'd0, rx_drop}, 32'd0);
      receivable = 1'b1;
      recv_byte(8'h01, 1'b0, "c0");
      recv_byte(8'h02, 1'b0, "c1");
      recv_byte(8'h03, 1'b0, "c2");
      recv_byte(8'h04, 1'b1, "c3");
      chk("to_clean_valid", {31'd0, rx_word_valid}, 32'd1);
      chk("to_clean_word", rx_word, 32'h04030201);
      rx_word_ready = 1'b1;
      tick();
      rx_word_ready = 1'b0;

      // Simultaneous send_ack and recv_ack
      tx_word = 32'hCAFEF00D;
      tx_word_valid = 1'b1;
      receivable = 1'b1;
      wait_ready("cc_rdy");
      k = 0;
      while (!(send_flag && recv_flag) && k < 50) begin
         tick();
         k++;
      end
      chk("cc_both_flags", {30'd0, send_flag, recv_flag}, 32'd3);
      chk("cc_sdata0", {24'd0, send_data}, 32'h0D);
      recv_data = 8'h5A;
      recv_ack = 1'b1;
      send_ack = 1'b1;
      tick();
      recv_ack = 1'b0;
      send_ack = 1'b0;
      chk("cc_flags_fall", {30'd0, send_flag, recv_flag}, 32'd0);
      send_byte_ack(8'hF0, "cc1");
      send_byte_ack(8'hFE, "cc2");
      send_byte_ack(8'hCA, "cc3");
      recv_byte(8'h6B, 1'b0, "cr1");
      recv_byte(8'h7C, 1'b0, "cr2");
      recv_byte(8'h8D, 1'b1, "cr3");
      chk("cc_rx_word", rx_word, 32'h8D7C6B5A);
      chk("cc_rx_valid", {31'd0, rx_word_valid}, 32'd1);
      rx_word_ready = 1'b1;
      tick();
      rx_word_ready = 1'b0;
      chk("cc_rx_clear", {31'd0, rx_word_valid}, 32'd0);

      // Reset while waiting for ack of the third byte
      tx_word = 32'h55667788;
      tx_word_valid = 1'b1;
      wait_ready("rr_rdy");
      send_byte_ack(8'h88, "rr0");
      send_byte_ack(8'h77, "rr1");
      k = 0;
      while (!send_flag && k < 20) begin
         tick();
         k++;
      end
      chk("rr_byte2", {23'd0, send_flag, send_data}, {23'd0, 1'b1, 8'h66});
      RST = 1'b0;
      #1;
      chk("rr_flag_async", {31'd0, send_flag}, 32'd0);
      chk("rr_data_async", {24'd0, send_data}, 32'd0);
      tick();
      tick();
      tx_word = 32'h99AABBCC;
      tx_word_valid = 1'b1;
      snap = rdy_cnt;
      RST = 1'b1;
      wait_ready("rr_new_rdy");
      send_byte_ack(8'hCC, "n0");
      send_byte_ack(8'hBB, "n1");
      send_byte_ack(8'hAA, "n2");
      send_byte_ack(8'h99, "n3");
      tick();
      chk("rr_rdy_once", rdy_cnt - snap, 32'd1);

      chk("drop_total", drop_cnt, 32'd1);
      chk("req_while_valid", rflag_while_valid, 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_word_bridge.md
UART_WORD_BRIDGE -- requirements
Module: uart_word_bridge

Interface
REQ-001 SHALL have parameter RX_TIMEOUT, default 1000000, meaning the number of idle cycles after which a partial received word is discarded.
REQ-002 SHALL have the following ports, all synchronous to CLK:
- CLK  in  1  clock.
- RST  in  1  reset; one clock, reset asynchronous and active-low.
- tx_word_valid  in  1  upstream has a 32-bit word to send.
- tx_word  in  32  word to transmit.
- tx_word_ready  out  1  word accepted this cycle.
- rx_word_valid  out  1  assembled word available.
- rx_word  out  32  assembled word.
- rx_word_ready  in  1  downstream consumes rx_word.
- rx_drop  out  1  one-cycle pulse when a partial word is discarded.
- send_flag  out  1  byte write request to the UART send FIFO.
- send_data  out  8  byte to the UART.
- send_ack  in  1  UART accepted the byte.
- sendable  in  1  UART send FIFO not full.
- recv_flag  out  1  byte read request to the UART receive FIFO.
- recv_data  in  8  byte from the UART.
- recv_ack  in  1  recv_data valid.
- receivable  in  1  UART receive FIFO non-empty.

Function
REQ-003 TX FSM SHALL have states TX_IDLE, TX_REQ and TX_WAIT.
REQ-004 In TX_IDLE with tx_word_valid=1, the block SHALL:
- assert tx_word_ready for exactly that cycle;
- latch tx_word into a 32-bit shift register;
- clear the byte index;
- go to TX_REQ.
REQ-005 In TX_REQ, when sendable=1, the block SHALL drive send_data = shift[7:0] (LSB byte first) and set send_flag=1, then go to TX_WAIT.
REQ-006 If sendable=0, TX_REQ SHALL hold with send_flag=0; there is no timeout on the send side.
REQ-007 In TX_WAIT, send_flag and send_data SHALL stay stable until the first cycle send_ack=1.
REQ-008 In that send_ack cycle the block SHALL:
- deassert send_flag on the next edge;
- shift right by 8 and increment the index;
- go to TX_REQ if index<3, else TX_IDLE.
REQ-009 A word SHALL always produce exactly 4 send_ack handshakes, and tx_word_ready SHALL NOT assert again before the 4th.
REQ-010 RX FSM SHALL have states RX_IDLE, RX_WAIT and RX_FULL.
REQ-011 In RX_IDLE with receivable=1 and rx_word_valid=0, the block SHALL assert recv_flag and go to RX_WAIT.
REQ-012 In RX_WAIT, recv_flag SHALL be held until recv_ack=1.
REQ-013 On the recv_ack cycle the block SHALL:
- capture recv_data into byte lane [index*8 +: 8];
- increment the index and reset the idle counter;
- deassert recv_flag;
- go to RX_FULL if the index was 3, else RX_IDLE.
REQ-014 RX_FULL SHALL drive rx_word_valid=1 with rx_word stable until the cycle rx_word_ready=1, then clear the index and go to RX_IDLE.
REQ-015 No new byte SHALL be requested while rx_word_valid=1 (back-pressure holds in the UART FIFO).
REQ-016 A 32-bit idle counter SHALL increment each cycle the RX FSM is in RX_IDLE with index≠0 and no recv_ack.
REQ-017 When the idle counter reaches RX_TIMEOUT-1, the block SHALL:
- clear the index and the counter;
- pulse rx_drop for one cycle;
- leave rx_word contents undefined-but-stable.
REQ-018 The idle counter SHALL be 0 whenever index=0.
REQ-019 TX and RX paths SHALL be fully independent; simultaneous send_ack and recv_ack in one cycle SHALL both be honoured.
REQ-020 recv_ack or send_ack arriving in a state other than RX_WAIT or TX_WAIT respectively SHALL be ignored.
REQ-021 All outputs SHALL be registered; tx_word_ready is the registered acceptance strobe for the same-cycle tx_word sample.

Reset
REQ-022 While RST=0 the block SHALL asynchronously force:
- both FSMs to IDLE;
- tx_word_ready, send_flag, recv_flag, rx_word_valid and rx_drop to 0;
- send_data, rx_word, the shift register, indices and counters to 0.
REQ-023 Reset asserted mid-word SHALL discard any partial TX or RX word without emitting further handshakes after release.
REQ-024 The first tx_word_ready after reset release SHALL occur no earlier than the second rising CLK edge.

Verification
REQ-025 Send: sendable=1, tx_word=0x12345678 valid, send_ack 2 cycles after each send_flag -> send_data sequence 78,56,34,12; tx_word_ready pulses once.
REQ-026 Back-pressure: sendable=0 after 2nd byte for 50 cycles -> send_flag low throughout; bytes 34,12 follow once sendable=1.
REQ-027 Receive: bytes EF,BE,AD,DE delivered via recv_ack -> rx_word=0xDEADBEEF; rx_word_valid held until rx_word_ready; no recv_flag while valid.
REQ-028 Timeout: RX_TIMEOUT=16, 2 bytes then silence -> rx_drop pulse 16 cycles after the last recv_ack; next 4 bytes form a clean word.
REQ-029 Concurrency: send_ack and recv_ack in the same cycle -> both indices advance; data intact.
REQ-030 Reset during TX_WAIT after byte 2 -> send_flag=0 immediately; tx_word_ready=1 on the next valid word, which is sent from byte 0.
